// File: rtl/vx_dispatch_pkg.sv
// Shared types and helpers for the dispatch router and its per-channel FIFOs.
package vx_dispatch_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } dispatch_state_e;

  localparam int STALL_CNT_W = 32;

  // Any selector at or beyond the channel count is a NOP and is dropped.
  function automatic logic unit_is_nop(input int unsigned unit, input int unsigned num_units);
    return (unit >= num_units);
  endfunction

endpackage

// File: rtl/vx_dispatch_router_if.sv
// Instruction input and per-channel output bus of the dispatch router.
interface vx_dispatch_router_if #(
  parameter int NUM_UNITS = 5,
  parameter int DATAW     = 64,
  parameter int UNIT_BITS = $clog2(NUM_UNITS + 1)
);
  // Handshake: a transfer happens on a clock edge where valid && ready are both 1;
  // the producer holds valid/payload stable until that edge, ready never depends on it.
  logic                       in_valid;
  logic                       in_ready;
  logic [UNIT_BITS-1:0]       in_unit;
  logic                       in_barrier;
  logic [DATAW-1:0]           in_data;
  logic [NUM_UNITS-1:0]       out_valid;
  logic [NUM_UNITS-1:0]       out_ready;
  logic [NUM_UNITS*DATAW-1:0] out_data;

  modport master (
    output in_valid, in_unit, in_barrier, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_unit, in_barrier, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/vx_dispatch_fifo.sv
// Per-channel elastic FIFO; entries are visible one cycle after the push edge.
module vx_dispatch_fifo #(
  parameter int DATAW = 64,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push_i,
  input  logic [DATAW-1:0] data_in_i,
  output logic             full_o,
  output logic             valid_out_o,
  input  logic             ready_out_i,
  output logic [DATAW-1:0] data_out_o,
  output logic             empty_o
);
  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [DATAW-1:0] mem_q [DEPTH];
  logic [PTRW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTRW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNTW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o      = (count_q == CNTW'(DEPTH));
  assign empty_o     = (count_q == '0);
  assign valid_out_o = !empty_o;
  assign data_out_o  = mem_q[rd_ptr_q];
  assign do_push     = push_i && !full_o;
  assign do_pop      = valid_out_o && ready_out_i;

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (do_push) mem_q[wr_ptr_q] <= data_in_i;
    end
  end

endmodule

// File: rtl/vx_dispatch_router.sv
// Routes one instruction per cycle into per-unit FIFOs, with a draining barrier mode.
module vx_dispatch_router
  import vx_dispatch_pkg::*;
#(
  parameter int NUM_UNITS = 5,
  parameter int DATAW     = 64,
  parameter int DEPTH     = 2,
  parameter int UNIT_BITS = $clog2(NUM_UNITS + 1)
) (
  input  logic                   clk,
  input  logic                   reset,
  vx_dispatch_router_if.slave    bus,
  output logic                   busy,
  output logic [STALL_CNT_W-1:0] perf_stalls,
  output dispatch_state_e        dbg_state_o
);
  dispatch_state_e        state_q;
  logic [STALL_CNT_W-1:0] stall_cnt_q;
  logic [NUM_UNITS-1:0]   full, empty, push;
  logic                   is_nop, target_full, all_empty, barrier_ok, accept;

  assign is_nop     = unit_is_nop(32'(bus.in_unit), NUM_UNITS);
  assign all_empty  = &empty;
  assign barrier_ok = !bus.in_barrier || all_empty;

  always_comb begin
    target_full = 1'b0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (32'(bus.in_unit) == 32'(i)) target_full = full[i];
    end
  end

  // Uses registered FIFO counts only, so out_ready never reaches in_ready.
  assign bus.in_ready = (state_q == IDLE) && (is_nop || (!target_full && barrier_ok));
  assign accept       = bus.in_valid && bus.in_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
    end else begin
      case (state_q)
        IDLE:    if (accept && bus.in_barrier) state_q <= HOLD;
        HOLD:    if (all_empty) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (bus.in_valid && !bus.in_ready && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign busy        = !all_empty || (state_q == HOLD);
  assign perf_stalls = stall_cnt_q;
  assign dbg_state_o = state_q;

  for (genvar g = 0; g < NUM_UNITS; g++) begin : g_chan
    assign push[g] = accept && (bus.in_unit == UNIT_BITS'(g));

    vx_dispatch_fifo #(
      .DATAW(DATAW),
      .DEPTH(DEPTH)
    ) u_fifo (
      .clk        (clk),
      .reset      (reset),
      .push_i     (push[g]),
      .data_in_i  (bus.in_data),
      .full_o     (full[g]),
      .valid_out_o(bus.out_valid[g]),
      .ready_out_i(bus.out_ready[g]),
      .data_out_o (bus.out_data[g*DATAW +: DATAW]),
      .empty_o    (empty[g])
    );
  end

endmodule

// File: doc/vx_dispatch_router.md
Name: vx_dispatch_router

Overview:
- Parametrised successor to the fixed five-unit dispatch stage.
- Routes one decoded, operand-ready instruction per cycle to one of NUM_UNITS execution-unit channels.
- Each channel has its own DEPTH-entry elastic FIFO in place of a single skid register.
- Adds a serialising barrier mode (fence/CSR-style drain) and a saturating dispatch-stall performance counter.
- Sits between the ibuffer/GPR-read stage and the execution units.

Parameters:
- NUM_UNITS, 5: number of execution-unit channels; 2..16.
- DATAW, 64: payload width per instruction, packed by the caller.
- DEPTH, 2: entries per channel FIFO; power of two, ≥2.
- UNIT_BITS, $clog2(NUM_UNITS+1): width of the unit selector, which includes one NOP code.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- in_valid  in  1  instruction present.
- in_ready  out  1  instruction accepted this cycle (when in_valid && in_ready).
- in_unit  in  UNIT_BITS  target channel; any value ≥ NUM_UNITS is a NOP.
- in_barrier  in  1  serialising instruction.
- in_data  in  DATAW  payload.
- out_valid  out  NUM_UNITS  per-channel valid.
- out_ready  in  NUM_UNITS  per-channel ready.
- out_data  out  NUM_UNITS*DATAW  channel i occupies bits [i*DATAW +: DATAW].
- busy  out  1  any FIFO non-empty, or FSM in HOLD.
- perf_stalls  out  32  count of cycles with in_valid && !in_ready.

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - All FIFOs empty; out_valid = 0.
  - out_data is don't-care but must not be X-propagating in simulation; data registers are reset to 0.
  - FSM in IDLE; perf_stalls = 0; busy = 0.
  - Reset asserted mid-operation discards all queued entries on the next edge, with no partial drain.
- Routing:
  - A NOP (in_unit ≥ NUM_UNITS) is accepted whenever the FSM is in IDLE and is dropped.
  - Otherwise in_ready = (state == IDLE) && !full[in_unit] && barrier_ok.
- Barrier:
  - barrier_ok = !in_barrier || all FIFOs empty.
- FSM: two states, IDLE and HOLD.
  - IDLE → HOLD when a barrier instruction is accepted.
  - In HOLD, in_ready = 0.
  - HOLD → IDLE on the first cycle in which all FIFOs are empty. That instruction is accepted no earlier than the next cycle.
  - A barrier with a NOP unit still enters HOLD, then exits on the next cycle if all FIFOs are empty.
- FIFO timing:
  - Write on accept at edge t; the entry is visible on out_valid/out_data after edge t, so a cycle t+1 consumer sees it (1-cycle latency, no bypass).
  - Pop when out_valid[i] && out_ready[i].
  - Order is preserved per channel only; there is no cross-channel ordering except through barriers.
- Full handling:
  - in_ready ignores same-cycle pops: a full FIFO refuses a push even while popping.
  - There must be no combinational path from out_ready to in_ready.
- Simultaneous push/pop on a non-full, non-empty FIFO: count unchanged; pointers wrap modulo DEPTH.
- Count width is $clog2(DEPTH)+1, so full and empty are unambiguous.
- perf_stalls: +1 per stall cycle, saturating at 32'hFFFF_FFFF with no wrap.
- No payload inspection; DATAW is opaque.

Decomposition:
- Shared package vx_dispatch_pkg:
  - dispatch_state_e {IDLE, HOLD}.
  - Function unit_is_nop(unit, NUM_UNITS).
  - Localparam for stall-counter width (32).
- One sub-module, vx_dispatch_fifo:
  - Parameters DATAW and DEPTH.
  - Ports: push, data_in, full, valid_out, ready_out, data_out, empty.
  - Instantiated NUM_UNITS times under a generate loop.

Test Plan:
1. NUM_UNITS=5, DEPTH=2, all out_ready=1; send unit 0,1,2,3,4 on back-to-back cycles → each out_valid[i] pulses exactly one cycle after its accept; in_ready stays 1; perf_stalls = 0.
2. out_ready[2]=0; send 3 instructions to unit 2 → first 2 accepted, third stalls; perf_stalls increments each cycle; raise out_ready[2] → the stalled instruction is accepted one cycle after the first pop; payloads emerge in order A, B, C.
3. Load unit 1 with 1 entry, out_ready[1]=0; present in_barrier to unit 3 → in_ready=0 until unit 1 drains. After the barrier is accepted: in HOLD, a unit-0 instruction waits until the unit-3 FIFO pops → FSM returns to IDLE, unit 0 accepted the cycle after.
4. in_unit=7 (NOP) while unit 0 is full → accepted in 1 cycle; no out_valid asserted; busy unchanged.
5. Preload perf_stalls near saturation via sustained stall (force/backdoor to 32'hFFFF_FFFE) → reads FFFF_FFFF after 1 more stall cycle and stays there.
6. Fill DEPTH=4 FIFOs on 3 channels, assert reset for 1 cycle mid-stream → next cycle out_valid=0, busy=0, FSM=IDLE, perf_stalls=0; a new instruction is then accepted normally.
